// File: rtl/lpif_tx_concat_param.sv
// LPIF TX concatenation: packs a flat upstream word across NUM_CH PHY channels and inserts
// counter-driven strobe/marker bits, with online gating and a sticky underrun flag.
module lpif_tx_concat_param #(
  parameter int NUM_CH     = 2,
  parameter int CH_WIDTH   = 40,
  parameter int DATA_WIDTH = 42,
  parameter int STB_LOC    = 1,
  parameter int MRK_LOC    = 39,
  parameter int MRK_RATIO  = 4,
  parameter int STB_PERIOD = 8,
  parameter int REG_PHY    = 1
) (
  input  logic                         clk_wr,
  input  logic                         rst_wr,
  input  logic                         tx_online,
  input  logic                         m_gen2_mode,
  input  logic [DATA_WIDTH-1:0]        tx_upstream_data,
  input  logic                         tx_upstream_valid,
  output logic                         tx_upstream_ready,
  output logic [NUM_CH*CH_WIDTH-1:0]   tx_phy,
  output logic                         tx_underrun,
  input  logic                         tx_underrun_clr
);

  localparam int SLOTS  = CH_WIDTH - 2;
  localparam int STB_W  = (STB_PERIOD > 1) ? $clog2(STB_PERIOD) : 1;
  localparam int MRK_W  = (MRK_RATIO > 1) ? $clog2(MRK_RATIO) : 1;
  localparam int LO_LOC = (STB_LOC < MRK_LOC) ? STB_LOC : MRK_LOC;
  localparam int HI_LOC = (STB_LOC < MRK_LOC) ? MRK_LOC : STB_LOC;

  if (DATA_WIDTH > NUM_CH * SLOTS) begin : g_chk_width
    $error("DATA_WIDTH does not fit in NUM_CH*(CH_WIDTH-2) payload slots");
  end
  if (STB_LOC == MRK_LOC) begin : g_chk_loc
    $error("STB_LOC and MRK_LOC must differ");
  end

  logic             online;
  logic [STB_W-1:0] stb_cnt;
  logic [MRK_W-1:0] mrk_cnt;
  logic             mode_q;
  logic             mode_chg;
  logic             stb_bit;
  logic             mrk_bit;
  logic             beat_ok;
  logic             underrun_set;
  logic [NUM_CH*CH_WIDTH-1:0] phy_d;

  // Online is held off while reset is asserted so nothing leaks out combinationally.
  assign online            = tx_online & ~rst_wr;
  assign tx_upstream_ready = online;
  assign mode_chg          = m_gen2_mode ^ mode_q;
  assign stb_bit           = online & (stb_cnt == '0);
  assign mrk_bit           = online & (m_gen2_mode ? (mrk_cnt == MRK_W'(MRK_RATIO - 1)) : 1'b1);
  assign beat_ok           = online & tx_upstream_valid;
  assign underrun_set      = online & ~tx_upstream_valid;

  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      stb_cnt <= '0;
      mrk_cnt <= '0;
      mode_q  <= 1'b0;
    end else begin
      mode_q <= m_gen2_mode;
      if (!online) begin
        stb_cnt <= '0;
        mrk_cnt <= '0;
      end else begin
        stb_cnt <= (stb_cnt == STB_W'(STB_PERIOD - 1)) ? '0 : stb_cnt + STB_W'(1);
        if (mode_chg || !m_gen2_mode || (mrk_cnt == MRK_W'(MRK_RATIO - 1)))
          mrk_cnt <= '0;
        else
          mrk_cnt <= mrk_cnt + MRK_W'(1);
      end
    end
  end

  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr)
      tx_underrun <= 1'b0;
    else if (underrun_set)
      tx_underrun <= 1'b1;
    else if (tx_underrun_clr)
      tx_underrun <= 1'b0;
  end

  // Each payload bit knows its data slot at elaboration: slot index skips the two overhead bits.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    for (genvar b = 0; b < CH_WIDTH; b++) begin : g_bit
      if (b == STB_LOC) begin : g_stb
        assign phy_d[c*CH_WIDTH + b] = stb_bit;
      end else if (b == MRK_LOC) begin : g_mrk
        assign phy_d[c*CH_WIDTH + b] = mrk_bit;
      end else begin : g_dat
        localparam int S = c*SLOTS + b - ((b > LO_LOC) ? 1 : 0) - ((b > HI_LOC) ? 1 : 0);
        if (S < DATA_WIDTH) begin : g_used
          assign phy_d[c*CH_WIDTH + b] = beat_ok & tx_upstream_data[S];
        end else begin : g_pad
          assign phy_d[c*CH_WIDTH + b] = 1'b0;
        end
      end
    end
  end

  if (REG_PHY != 0) begin : g_reg
    logic [NUM_CH*CH_WIDTH-1:0] phy_q;
    always_ff @(posedge clk_wr or posedge rst_wr) begin
      if (rst_wr)
        phy_q <= '0;
      else
        phy_q <= phy_d;
    end
    assign tx_phy = phy_q;
  end else begin : g_comb
    assign tx_phy = phy_d;
  end

endmodule
